// File: rtl/minha_ram16k_block.sv
// 16K x 16 word RAM split into four 4K banks; combinational read, clocked write,
// asynchronous active-high reset that clears every word.
module minha_ram16k_block #(
  parameter int LARGURA_DADOS = 16,
  parameter int LARGURA_END   = 14
) (
  input  logic                     clock_sistema,
  input  logic                     reset_sistema,
  input  logic [LARGURA_DADOS-1:0] entrada_dados,
  input  logic [LARGURA_END-1:0]   endereco_mem,
  input  logic                     controle_escrita,
  output logic [LARGURA_DADOS-1:0] saida_dados
);

  localparam int BITS_BANCO   = 2;
  localparam int NUM_BANCOS   = 1 << BITS_BANCO;
  localparam int BITS_PALAVRA = LARGURA_END - BITS_BANCO;
  localparam int PALAVRAS     = 1 << BITS_PALAVRA;

  logic [BITS_BANCO-1:0]    banco_sel;
  logic [BITS_PALAVRA-1:0]  palavra_sel;
  logic [NUM_BANCOS-1:0]    escrita_banco_d;
  logic [LARGURA_DADOS-1:0] mem_q [NUM_BANCOS][PALAVRAS];

  assign banco_sel   = endereco_mem[LARGURA_END-1:BITS_PALAVRA];
  assign palavra_sel = endereco_mem[BITS_PALAVRA-1:0];

  // One-hot bank write strobe; at most one bank is touched per edge.
  always_comb begin
    escrita_banco_d = '0;
    if (controle_escrita) begin
      escrita_banco_d[banco_sel] = 1'b1;
    end
  end

  always_ff @(posedge clock_sistema or posedge reset_sistema) begin
    if (reset_sistema) begin
      for (int b = 0; b < NUM_BANCOS; b++) begin
        for (int w = 0; w < PALAVRAS; w++) begin
          mem_q[b][w] <= '0;
        end
      end
    end else begin
      for (int b = 0; b < NUM_BANCOS; b++) begin
        if (escrita_banco_d[b]) begin
          mem_q[b][palavra_sel] <= entrada_dados;
        end
      end
    end
  end

  // Output is forced low during reset so it reads zero in the same time step.
  always_comb begin
    saida_dados = '0;
    if (!reset_sistema) begin
      saida_dados = mem_q[banco_sel][palavra_sel];
    end
  end

endmodule

// File: tb/tb_minha_ram16k_block.sv
// Self-checking bench for minha_ram16k_block: directed cases plus randomized
// traffic compared against a flat-array reference memory.
module tb_minha_ram16k_block;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] din;
  logic [15:0] dout;
  logic [13:0] addr;
  logic        we;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] ref_mem [16384];

  minha_ram16k_block dut (
    .clock_sistema   (clk),
    .reset_sistema   (rst),
    .entrada_dados   (din),
    .endereco_mem    (addr),
    .controle_escrita(we),
    .saida_dados     (dout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (addr %0d)", tag, got, exp, addr);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16384; i++) ref_mem[i] = 16'h0000;
  endtask

  task automatic write_word(input logic [13:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a;
    din  = d;
    we   = 1'b1;
    @(posedge clk);
    if (!rst) ref_mem[a] = d;
    #1;
    we = 1'b0;
  endtask

  task automatic read_check(input string tag, input logic [13:0] a);
    addr = a;
    #1;
    check(tag, dout, ref_mem[a]);
  endtask

  logic [13:0] dir_addr [12];
  logic [15:0] dir_data [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    dir_addr = '{14'd0, 14'd1, 14'd2, 14'd3, 14'd4, 14'd5,
                 14'd100, 14'd200, 14'd300, 14'd400, 14'd500, 14'd16383};
    dir_data = '{16'hAAAA, 16'h5555, 16'hF0F0, 16'h0F0F, 16'hFF00, 16'h00FF,
                 16'hAA55, 16'h55AA, 16'hCCCC, 16'h3333, 16'hA5A5, 16'h5A5A};

    rst  = 1'b1;
    we   = 1'b0;
    din  = 16'h0000;
    addr = 14'd0;
    model_clear();
    #1;
    check("reset_out", dout, 16'h0000);

    // Write attempted during reset must be ignored
    @(negedge clk);
    addr = 14'd7;
    din  = 16'h1234;
    we   = 1'b1;
    @(posedge clk);
    #1;
    check("rst_wr_ignored", dout, 16'h0000);
    we = 1'b0;
    addr = 14'd16383;
    #1;
    check("reset_out_top", dout, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    read_check("post_rst_addr7", 14'd7);

    // Directed write-then-read
    for (int i = 0; i < 12; i++) begin
      write_word(dir_addr[i], dir_data[i]);
      if (i == 0) begin
        #1;
        check("first_wr_after_rst", dout, 16'hAAAA);
      end
    end
    for (int i = 0; i < 12; i++) begin
      addr = dir_addr[i];
      #1;
      check("dir_readback", dout, dir_data[i]);
    end

    // Write protection
    @(negedge clk);
    addr = 14'd0;
    din  = 16'hFFFF;
    we   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("wr_protect", dout, 16'hAAAA);

    // Overwrite with read-during-write
    @(negedge clk);
    addr = 14'd0;
    din  = 16'hFFFF;
    we   = 1'b1;
    #1;
    check("rdw_old", dout, 16'hAAAA);
    @(posedge clk);
    ref_mem[0] = 16'hFFFF;
    #1;
    check("rdw_new", dout, 16'hFFFF);
    we = 1'b0;
    addr = 14'd1;
    #1;
    check("overwrite_neighbor", dout, 16'h5555);

    // Bank isolation
    write_word(14'h0010, 16'h1234);
    write_word(14'h1010, 16'h5678);
    addr = 14'h0010; #1; check("bank0", dout, 16'h1234);
    addr = 14'h1010; #1; check("bank1", dout, 16'h5678);
    addr = 14'h2010; #1; check("bank2", dout, 16'h0000);
    addr = 14'h3010; #1; check("bank3", dout, 16'h0000);

    // Combinational read tracking mid-cycle
    @(posedge clk);
    #2;
    addr = 14'd1;     #1; check("comb_a1", dout, 16'h5555);
    addr = 14'd16383; #1; check("comb_top", dout, 16'h5A5A);
    addr = 14'd1;     #1; check("comb_a1_again", dout, 16'h5555);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      logic [13:0] a;
      logic [15:0] d;
      logic        w;
      a = ($urandom_range(0, 1) == 0) ? {2'($urandom_range(0, 3)), 8'h00, 4'($urandom_range(0, 15))}
                                      : 14'($urandom);
      d = 16'($urandom);
      w = 1'($urandom_range(0, 1));
      @(negedge clk);
      addr = a;
      din  = d;
      we   = w;
      #1;
      check("rnd_pre", dout, ref_mem[a]);
      @(posedge clk);
      if (w) ref_mem[a] = d;
      #1;
      check("rnd_post", dout, ref_mem[a]);
      we = 1'b0;
    end

    // Async reset pulsed between edges
    @(posedge clk);
    #2;
    addr = 14'd0;
    rst  = 1'b1;
    #1;
    check("async_rst_now", dout, 16'h0000);
    addr = 14'd100;   #1; check("rst_a100", dout, 16'h0000);
    addr = 14'd16383; #1; check("rst_top", dout, 16'h0000);
    rst = 1'b0;
    model_clear();
    read_check("after_rst_a0", 14'd0);
    read_check("after_rst_a100", 14'd100);
    read_check("after_rst_top", 14'd16383);
    read_check("after_rst_bank1", 14'h1010);

    write_word(14'h02A5, 16'hBEEF);
    #1;
    check("wr_after_rst2", dout, 16'hBEEF);

    // More random traffic, then sparse readback scan
    for (int i = 0; i < 200; i++) begin
      write_word(14'($urandom), 16'($urandom));
    end
    for (int i = 0; i < 300; i++) begin
      read_check("scan", 14'($urandom));
    end
    for (int i = 0; i < 12; i++) begin
      read_check("scan_dir", dir_addr[i]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
